// File: rtl/uart_pkg.sv
// Shared UART constants, arbiter state encoding and defaults for the tx arbiter slice.
package uart_pkg;

  localparam int CLK_HZ_50M  = 50_000_000;
  localparam int CLK_HZ_12M  = 12_000_000;
  localparam int BAUD_9600   = 9600;
  localparam int BAUD_115200 = 115200;

  // Clock cycles per bit for each supported clock/baud pairing.
  localparam int BPS_50M_9600   = CLK_HZ_50M / BAUD_9600;
  localparam int BPS_50M_115200 = CLK_HZ_50M / BAUD_115200;
  localparam int BPS_12M_9600   = CLK_HZ_12M / BAUD_9600;
  localparam int BPS_12M_115200 = CLK_HZ_12M / BAUD_115200;

  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between client requesters, the arbiter and the byte transmitter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Client side: req[k] is a level held with req_data stable until ack[k]
  // pulses for one cycle. Transmitter side: tx_en_sig/tx_data stay steady
  // until a single-cycle tx_done; tx_en_sig then drops for >= 2 cycles.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_en_sig;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;
  logic                      timeout_err;
  arb_state_t                dbg_state;
  logic [IDX_W-1:0]          dbg_ptr;

  modport master (
    input  req, req_data, tx_done,
    output ack, tx_en_sig, tx_data, busy, grant_id, timeout_err, dbg_state, dbg_ptr
  );

  modport slave (
    output req, req_data, tx_done,
    input  ack, tx_en_sig, tx_data, busy, grant_id, timeout_err, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  always_comb begin
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> ptr);
    valid = |rot;
    idx   = '0;
    // Descending scan so the smallest offset from ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ clients.
// Optional SEND watchdog is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be >= 1 and TIMEOUT_CYC >= 2");
  end

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_byte;
  logic [IDX_W-1:0]  ptr_after;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign pick_byte = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
  // Whatever ends a byte (done or watchdog), the granted client moves to the back.
  assign ptr_after = IDX_W'(rr_next(int'(bus.grant_id), NUM_REQ));

  assign bus.dbg_state = state;
  assign bus.dbg_ptr   = ptr;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] wd;
  logic        wd_expired;
  assign wd_expired = (wd == 16'(TIMEOUT_CYC - 1));
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      bus.tx_en_sig <= 1'b0;
      bus.tx_data   <= '0;
      bus.ack       <= '0;
      bus.busy      <= 1'b0;
      bus.grant_id  <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd              <= '0;
      bus.timeout_err <= 1'b0;
`endif
    end else begin
      bus.ack <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state         <= ST_SEND;
            bus.tx_en_sig <= 1'b1;
            bus.tx_data   <= pick_byte;
            bus.grant_id  <= pick_idx;
            bus.busy      <= 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
            wd <= '0;
`endif
          end
        end
        ST_SEND: begin
          // tx_done wins over a simultaneous watchdog expiry.
          if (bus.tx_done) begin
            state         <= ST_DONE;
            bus.tx_en_sig <= 1'b0;
            bus.ack       <= NUM_REQ'(1) << bus.grant_id;
            ptr           <= ptr_after;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (wd_expired) begin
            state           <= ST_DONE;
            bus.tx_en_sig   <= 1'b0;
            bus.timeout_err <= 1'b1;
            ptr             <= ptr_after;
          end else begin
            wd <= wd + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          bus.tx_en_sig <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed steps plus random traffic
// against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO       = 16;
  localparam int LONG_DLY = 10;
`else
  localparam int TO       = 4096;
  localparam int LONG_DLY = 1040;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (W),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = idle, 1 = sending, 2 = post-byte gap.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_grant = 0;
  int          m_wd    = 0;
  logic [W-1:0] m_byte = '0;
  logic [N-1:0] m_ack  = '0;
  logic        m_to    = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sent_log[$];
  int           grant_log[$];

  int           tx_dly    = 0;
  int           tx_cnt    = 0;
  logic [N-1:0] drop_mask = '1;
  int           low_run   = 99;
  logic         prev_en   = 1'b0;
  logic [W-1:0] last_sent = '0;
  int           ack_total = 0;
  int           to_total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_search(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_grant = 0; m_wd = 0;
    m_byte = '0; m_ack = '0; m_to = 1'b0;
    exp_q.delete();
    prev_en = 1'b0; low_run = 99; tx_cnt = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req_e, input logic [N*W-1:0] data_e,
                            input logic done_e);
    int g;
    m_ack = '0;
    m_to  = 1'b0;
    case (m_phase)
      0: begin
        g = rr_search(req_e, m_ptr);
        if (g >= 0) begin
          m_phase = 1;
          m_grant = g;
          m_byte  = data_e[g*W +: W];
          m_wd    = 0;
          exp_q.push_back(m_byte);
        end
      end
      1: begin
        if (done_e) begin
          m_phase = 2;
          m_ack   = N'(1) << m_grant;
          m_ptr   = (m_grant + 1) % N;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (m_wd == TO - 1) begin
          m_phase = 2;
          m_to    = 1'b1;
          m_ptr   = (m_grant + 1) % N;
          void'(exp_q.pop_back());
        end else begin
          m_wd++;
        end
`endif
      end
      default: m_phase = 0;
    endcase
  endtask

  // ---------------- driver: one clock, checks at the falling edge ----------------
  task automatic cycle();
    logic [N-1:0]   req_e;
    logic [N*W-1:0] data_e;
    logic           done_e;
    req_e  = bus.req;
    data_e = bus.req_data;
    done_e = bus.tx_done;
    @(negedge clk);
    model_step(req_e, data_e, done_e);
    chk("tx_en", bus.tx_en_sig, m_phase == 1);
    chk("busy", bus.busy, m_phase != 0);
    chk("ack", bus.ack, m_ack);
    chk("grant_id", bus.grant_id, m_grant);
    chk("ptr", bus.dbg_ptr, m_ptr);
    chk("timeout_err", bus.timeout_err, m_to);
    if (m_phase == 1) chk("tx_data", bus.tx_data, m_byte);
    if (bus.tx_en_sig && !prev_en) begin
      chk("en_gap", low_run >= 2, 1);
      grant_log.push_back(int'(bus.grant_id));
    end
    low_run = bus.tx_en_sig ? 0 : low_run + 1;
    if (bus.tx_en_sig) last_sent = bus.tx_data;
    if (bus.ack != '0) begin
      ack_total++;
      chk("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("sb_byte", last_sent, exp_q.pop_front());
      sent_log.push_back(last_sent);
    end
    if (bus.timeout_err) to_total++;
    prev_en = bus.tx_en_sig;
    bus.req = bus.req & ~(bus.ack & drop_mask);
    // Transmitter model: tx_done after tx_dly cycles of enable (0 = never).
    if (bus.tx_en_sig) begin
      tx_cnt++;
      bus.tx_done = (tx_dly != 0) && (tx_cnt == tx_dly);
    end else begin
      tx_cnt = 0;
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic run_idle(input string tag, input int max_cyc);
    int i;
    i = 0;
    while (!(m_phase == 0 && bus.req == '0 && !bus.tx_en_sig) && i < max_cyc) begin
      cycle();
      i++;
    end
    chk(tag, i < max_cyc, 1);
  endtask

  task automatic do_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_en", bus.tx_en_sig, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_ptr", bus.dbg_ptr, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    model_reset();
    bus.req     = '0;
    bus.tx_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int got;
    int a0;
    int t0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_done  = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_tx_en", bus.tx_en_sig, 0);
    chk("init_busy", bus.busy, 0);
    chk("init_ack", bus.ack, 0);
    chk("init_grant", bus.grant_id, 0);
    chk("init_ptr", bus.dbg_ptr, 0);
    chk("init_tx_data", bus.tx_data, 0);
    chk("init_timeout", bus.timeout_err, 0);
    rst_n = 1'b1;

    // Idle with no requests, plus a stray tx_done.
    cycle();
    bus.tx_done = 1'b1;
    cycle();
    cycle();
    chk("idle_busy", bus.busy, 0);

    // Single request from requester 2.
    tx_dly = LONG_DLY;
    drop_mask = '1;
    bus.req_data[2*W +: W] = 8'h55;
    bus.req = 4'b0100;
    cycle();
    chk("single_en", bus.tx_en_sig, 1);
    chk("single_data", bus.tx_data, 8'h55);
    chk("single_gid", bus.grant_id, 2);
    n = 1;
    got = 0;
    while (!got && n < LONG_DLY + 50) begin
      cycle();
      n++;
      if (bus.ack != '0) got = 1;
    end
    chk("single_ack_seen", got, 1);
    chk("single_ack_cycle", n, LONG_DLY + 1);
    chk("single_ack_val", bus.ack, 4'b0100);
    cycle();
    chk("single_ack_len", bus.ack, 0);
    chk("single_ptr", bus.dbg_ptr, 3);
    run_idle("single_idle", 10);

    // Reset in the middle of a byte.
    bus.req_data[1*W +: W] = 8'h3C;
    bus.req = 4'b0010;
    tx_dly = 0;
    repeat (5) cycle();
    chk("rst_pre_busy", bus.busy, 1);
    a0 = ack_total;
    do_reset_mid();
    repeat (3) cycle();
    chk("rst_no_ack", ack_total - a0, 0);

    // All four requesting.
    bus.req_data = {8'h01, 8'hBF, 8'hAA, 8'h55};
    bus.req = 4'b1111;
    tx_dly = 3;
    sent_log.delete();
    run_idle("all_run", 200);
    chk("all_count", sent_log.size(), 4);
    chk("all_b0", sent_log[0], 8'h55);
    chk("all_b1", sent_log[1], 8'hAA);
    chk("all_b2", sent_log[2], 8'hBF);
    chk("all_b3", sent_log[3], 8'h01);

    // Withdrawal mid-byte.
    bus.req_data[0 +: W] = 8'h77;
    bus.req = 4'b0001;
    tx_dly = 8;
    a0 = ack_total;
    sent_log.delete();
    repeat (3) cycle();
    bus.req = '0;
    bus.req_data[0 +: W] = 8'hFF;
    run_idle("wdraw_run", 50);
    chk("wdraw_ack", ack_total - a0, 1);
    chk("wdraw_byte", sent_log[0], 8'h77);

    // Fairness: requester 0 holds req, requester 1 joins during byte 0.
    do_reset_mid();
    bus.req_data[0 +: W] = 8'h10;
    drop_mask = 4'b1110;
    bus.req = 4'b0001;
    tx_dly = 6;
    grant_log.delete();
    repeat (2) cycle();
    bus.req_data[W +: W] = 8'h21;
    bus.req[1] = 1'b1;
    n = 0;
    while (grant_log.size() < 3 && n < 100) begin
      cycle();
      n++;
    end
    chk("fair_bound", n < 100, 1);
    chk("fair_g0", grant_log[0], 0);
    chk("fair_g1", grant_log[1], 1);
    chk("fair_g2", grant_log[2], 0);
    bus.req = '0;
    drop_mask = '1;
    run_idle("fair_idle", 50);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog: transmitter never completes.
    do_reset_mid();
    bus.req_data[0 +: W] = 8'hA1;
    bus.req_data[W +: W] = 8'hB2;
    bus.req = 4'b0011;
    tx_dly = 0;
    grant_log.delete();
    t0 = to_total;
    a0 = ack_total;
    repeat (25) cycle();
    chk("to_pulse", to_total - t0, 1);
    chk("to_no_ack", ack_total - a0, 0);
    chk("to_g0", grant_log[0], 0);
    chk("to_g1", grant_log[1], 1);
    bus.req = '0;
    run_idle("to_drain", 60);
`else
    t0 = to_total;
    chk("no_timeout", t0, 0);
`endif

    // Random traffic.
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!bus.req[k] && $urandom_range(0, 3) == 0) begin
          bus.req[k] = 1'b1;
          bus.req_data[k*W +: W] = W'($urandom);
        end else if (bus.req[k] && $urandom_range(0, 40) == 0) begin
          bus.req[k] = 1'b0;
        end
      end
      if (!bus.tx_en_sig) tx_dly = $urandom_range(1, 12);
      cycle();
    end
    bus.req = '0;
    run_idle("final_drain", 100);
    chk("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART byte transmitter among NUM_REQ requesters.
- Sequences the transmitter's enable/data/done handshake: latches the granted requester's byte, holds enable until the transmitter reports done, then acks the requester.
- Sits between client logic (status reporters, echo path, test-pattern generator) and the tx_module_3 instance driving tx_pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT_CYC, 4096, watchdog limit in clk cycles for one byte; used only with the optional feature. At 12 MHz / 115200 baud, 10 bits x 104 = 1040 cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  per-requester send request; level, held until ack.
- req_data  in  NUM_REQ*DATA_W  byte of requester k in bits [k*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle pulse: requester's byte fully transmitted.
- tx_en_sig  out  1  enable to transmitter.
- tx_data  out  DATA_W  byte to transmitter.
- tx_done  in  1  one-cycle completion pulse from transmitter.
- busy  out  1  high outside IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester.
- timeout_err  out  1  one-cycle abort pulse; tied 0 without the optional feature.

Behaviour:
- Reset values: state IDLE, tx_en_sig 0, tx_data 0, ack 0, busy 0, grant_id 0, rr pointer 0, timeout_err 0, watchdog 0.
- All outputs are registered.
- IDLE:
  - Search req starting at the rr pointer, wrapping modulo NUM_REQ; pick the first set bit.
  - If one is found, next cycle: SEND, tx_en_sig=1, tx_data=req_data[sel], grant_id=sel.
  - Grant latency is 1 cycle from req sampled high.
- SEND:
  - Hold tx_en_sig=1 and tx_data stable.
  - Ignore req changes. The byte is already latched, so a requester dropping req mid-byte still completes and still gets ack.
  - On tx_done=1: next cycle DONE, tx_en_sig=0, ack[grant_id]=1, rr pointer=(grant_id+1) mod NUM_REQ.
- DONE:
  - ack deasserts.
  - Next cycle IDLE.
  - Guarantees tx_en_sig low for at least 2 cycles (DONE + IDLE) between bytes, so the transmitter rearms.
- Fairness and back-to-back sends:
  - A requester holding req after its ack is re-considered only after the other pending requesters; its next byte takes effect in the IDLE after ack.
  - With all requesters always requesting, the grant order is 0,1,2,3,0,...
- Boundary conditions:
  - tx_done outside SEND is ignored.
  - req all-zero in IDLE: remain in IDLE, busy 0.
  - NUM_REQ=1 degenerates to a simple sequencer.
  - Asynchronous reset in any state returns immediately to reset values. tx_en_sig drops; no ack is issued for the in-flight byte.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in SEND and clears on entry to SEND.
  - If it reaches TIMEOUT_CYC-1 without tx_done: tx_en_sig=0, timeout_err=1 for one cycle, go to DONE with ack withheld, and advance the rr pointer past the granted requester.
  - tx_done in the same cycle as expiry counts as success: normal ack, no error.
- Undefined: no counter logic; timeout_err constant 0; SEND waits indefinitely.

Decomposition:
- Package uart_pkg:
  - BPS constants (50 MHz/12 MHz x 9600/115200).
  - DATA_W default.
  - State encoding IDLE/SEND/DONE.
  - Default TIMEOUT_CYC.
- One sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req and pointer.
  - Outputs: valid and index.
  - Reusable for a future receive-side dispatcher.

Test Plan:
- Single request: req=4'b0100, req_data byte2=8'h55, transmitter model pulses tx_done 1040 cycles after enable. Required response:
  - tx_en_sig rises 1 cycle after req, with tx_data=8'h55 and grant_id=2.
  - ack=4'b0100 for exactly 1 cycle, the cycle after tx_done.
  - Pointer becomes 3.
- All requesting: req=4'b1111 with bytes 8'h55, 8'hAA, 8'hBF, 8'h01, each requester dropping req on its ack. Required response: bytes sent in order 55, AA, BF, 01, with tx_en_sig low for at least 2 cycles between bytes.
- Fairness: requester 0 holds req permanently and requester 1 asserts during byte 0. Required response: grant order 0,1,0 and never 0,0 while requester 1 is pending.
- Request withdrawal: requester drops req mid-SEND. Required response: tx_data unchanged, tx_done still yields an ack pulse, then return to IDLE.
- Reset mid-operation: assert rst_n=0 mid-byte. Required response: tx_en_sig and busy go 0 asynchronously, no ack, and grant_id and pointer return to 0.
- Timeout (with UART_TX_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16): tx_done is never pulsed. Required response:
  - timeout_err pulses once on the 16th SEND cycle.
  - No ack is issued.
  - The next pending requester is granted.
